ahb_sub_mem: RTL and testbench
==============================

// Module: ahb_sub_mem
// PURPOSE
// AHB-Lite subordinate wrapping a word-addressed register memory; the endpoint behind the decoder/mux.
// Captures address phases, runs data phases with WAIT_STATES stalls, applies byte-lane writes.
// Flags illegal accesses with the two-cycle ERROR response.
// Drives its data phase with the shared AHBCommon_pkg types ahb_sub_state_t, ahb_resp_t and ahb_trans_t.
// PARAMETERS
// ADDR_W       32            HADDR width
// DATA_W       32            HWDATA/HRDATA width, power of 2, >=8
// DEPTH        256           memory depth in DATA_W words
// BASE_ADDR    32'h0000_0000 byte address of word 0
// WAIT_STATES  0             HREADYOUT-low cycles before each OKAY completion, 0..15
// PORTS
// HCLK       in   1        clock, all state on rising edge
// HRESET     in   1        asynchronous, active-high reset
// HSEL       in   1        subordinate select from decoder
// HADDR      in   ADDR_W   byte address
// HTRANS     in   2        ahb_trans_t
// HWRITE     in   1        1=write, 0=read
// HSIZE      in   3        log2(bytes per transfer)
// HWDATA     in   DATA_W   write data, sampled in data phase
// HREADY     in   1        bus-wide ready from mux
// HREADYOUT  out  1        this subordinate's ready
// HRESP      out  2        ahb_resp_t
// HRDATA     out  DATA_W   read data
// BEHAVIOUR
// - Reset (async, any cycle): state=STATE_IDLE, HREADYOUT=1, HRESP=RESP_OKAY, HRDATA=0, wait counter=0.
//   An in-flight write is dropped. Memory contents are not reset.
// - Address phase accepted iff HSEL && HREADY && HTRANS is TRANS_NONSEQ or TRANS_SEQ.
//   On acceptance, HADDR/HWRITE/HSIZE latch into addr_q/write_q/size_q.
// - IDLE/BUSY with HSEL: no state change. The data phase is zero-wait OKAY (HREADYOUT=1, HRESP=OKAY).
// - Legality check at acceptance. Illegal if any of:
//   HADDR outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8);
//   HSIZE > log2(DATA_W/8);
//   HADDR not aligned to HSIZE.
//   Illegal -> STATE_ERROR. Legal -> STATE_READ or STATE_WRITE per HWRITE.
// - READ/WRITE: the counter loads WAIT_STATES. While counter!=0: HREADYOUT=0, HRESP=OKAY, decrement.
//   When counter==0: HREADYOUT=1, HRESP=OKAY (completion cycle).
// - WRITE completion: on the completion edge, HWDATA bytes selected by size_q/addr_q lanes are written to mem[word(addr_q)].
//   Other lanes are unchanged. Little-endian lanes.
// - READ: HRDATA = full word mem[word(addr_q)] throughout STATE_READ. HRDATA=0 in all other states.
// - ERROR: cycle 1 HREADYOUT=0, HRESP=RESP_ERROR. Cycle 2 HREADYOUT=1, HRESP=RESP_ERROR.
//   No memory access occurs. WAIT_STATES does not apply.
// - Pipelining: in any cycle with HREADYOUT=1 (completion, ERROR cycle 2, or IDLE), a newly accepted address phase moves the FSM directly to its next state.
//   Otherwise the FSM returns to STATE_IDLE. No bubble between back-to-back transfers.
// - Write to word A followed immediately by a read of A returns the new data (the write commits before the read's data phase).
// - Address phases presented while HREADY=0 are ignored (the manager must hold them).
//   HSEL deasserting mid data phase does not abort the transfer.
// STRUCTURE
// - AHBCommon_pkg (existing) supplies ahb_resp_t, ahb_trans_t and ahb_sub_state_t.
//   Add ahb_size_t (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2, ...) there; the bench also uses it.
// - Sub-module ahb_byte_lane_dec: combinational (size, addr low bits) -> DATA_W/8 lane strobe.
//   Also reused by future subordinates.
// - Top level: FSM, wait counter, address/control regs, memory array.
// TESTING
// - WAIT_STATES=0: write 0xDEADBEEF @0x10 word, then read @0x10 back-to-back.
//   -> HREADYOUT stays 1; read data phase HRDATA=0xDEADBEEF, HRESP=OKAY.
// - WAIT_STATES=2: single read -> exactly 2 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with data.
// - Byte write 0xAA @0x13 over word 0x11223344 @0x10, then word read -> 0xAA223344.
// - Read @BASE_ADDR+DEPTH*4 -> HREADYOUT 0 then 1, HRESP=ERROR both cycles; next NONSEQ read @0x0 completes OKAY.
// - Halfword @0x11 (misaligned) or HSIZE=3 -> two-cycle ERROR; target word unchanged on readback.
// - Assert HRESET mid WAIT_STATES=3 write -> outputs to reset values immediately; later read shows old data.

Source files
------------

// File: rtl/AHBCommon_pkg.sv
// Shared AHB-Lite types for managers, interconnect and subordinates.
// ahb_size_t encodes HSIZE as log2(bytes per transfer).
`timescale 1ns/1ps
package AHBCommon_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } ahb_trans_t;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b01,
      RESP_RETRY = 2'b10,
      RESP_SPLIT = 2'b11
   } ahb_resp_t;

   typedef enum logic [2:0] {
      STATE_IDLE      = 3'd0,
      STATE_READ      = 3'd1,
      STATE_WRITE     = 3'd2,
      STATE_ERROR     = 3'd3,
      STATE_ERROR_END = 3'd4
   } ahb_sub_state_t;

   typedef enum logic [2:0] {
      SIZE_BYTE   = 3'd0,
      SIZE_HALF   = 3'd1,
      SIZE_WORD   = 3'd2,
      SIZE_DWORD  = 3'd3,
      SIZE_4WORD  = 3'd4,
      SIZE_8WORD  = 3'd5,
      SIZE_16WORD = 3'd6,
      SIZE_32WORD = 3'd7
   } ahb_size_t;

   function automatic logic trans_active(input ahb_trans_t t);
      return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Little-endian byte-lane strobe decoder: (transfer size, low address bits) -> lane enables.
// Lanes sharing the aligned block of the addressed byte are enabled.
`timescale 1ns/1ps
module ahb_byte_lane_dec
   import AHBCommon_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   localparam int unsigned LANES   = DATA_W / 8,
   localparam int unsigned LANE_AW = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  ahb_size_t          size,
   input  logic [LANE_AW-1:0] addr_lo,
   output logic [LANES-1:0]   strb
);

   always_comb begin
      strb = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         // Lane i is hit when it differs from the address only below the size boundary.
         if (((i ^ (32'(addr_lo) & (LANES - 1))) >> size) == 0) begin
            strb[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_sub_mem.sv
// AHB-Lite subordinate fronting a word-addressed register memory with optional wait states
// and a two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
`timescale 1ns/1ps
module ahb_sub_mem
   import AHBCommon_pkg::*;
#(
   parameter int unsigned        ADDR_W      = 32,
   parameter int unsigned        DATA_W      = 32,
   parameter int unsigned        DEPTH       = 256,
   parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
   parameter int unsigned        WAIT_STATES = 0
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic [1:0]        HRESP,
   output logic [DATA_W-1:0] HRDATA
);

   localparam int unsigned LANES      = DATA_W / 8;
   localparam int unsigned LOG2_LANES = $clog2(LANES);
   localparam int unsigned LANE_AW    = (LANES > 1) ? LOG2_LANES : 1;
   localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned MEM_BYTES  = DEPTH * LANES;

   ahb_sub_state_t    state, state_nx;
   logic [3:0]        wait_cnt, wait_nx;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   ahb_size_t         size_q;

   logic              accept, legal, advance;
   logic              in_range, size_ok, aligned;
   logic              ready_int;
   ahb_resp_t         resp_int;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W:0]   span;
   logic [ADDR_W-1:0] align_mask;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic [LANES-1:0]  strb;
   logic              wr_fire;

   assign accept = HSEL && HREADY && trans_active(ahb_trans_t'(HTRANS));

   // Legality is judged on the raw address phase so the ERROR path never touches memory.
   assign offset     = HADDR - BASE_ADDR;
   assign span       = (ADDR_W + 1)'(MEM_BYTES);
   assign in_range   = (HADDR >= BASE_ADDR) && ({1'b0, offset} < span);
   assign size_ok    = (HSIZE <= 3'(LOG2_LANES));
   assign align_mask = ~({ADDR_W{1'b1}} << HSIZE);
   assign aligned    = ((HADDR & align_mask) == '0);
   assign legal      = in_range && size_ok && aligned;

   always_comb begin
      state_nx  = state;
      ready_int = 1'b1;
      resp_int  = RESP_OKAY;
      case (state)
         STATE_READ, STATE_WRITE: ready_int = (wait_cnt == '0);
         STATE_ERROR: begin
            ready_int = 1'b0;
            resp_int  = RESP_ERROR;
            state_nx  = STATE_ERROR_END;
         end
         STATE_ERROR_END: resp_int = RESP_ERROR;
         default: ;
      endcase
      if (ready_int) begin
         if (!accept)     state_nx = STATE_IDLE;
         else if (!legal) state_nx = STATE_ERROR;
         else if (HWRITE) state_nx = STATE_WRITE;
         else             state_nx = STATE_READ;
      end
   end

   assign advance = ready_int && accept;

   always_comb begin
      wait_nx = wait_cnt;
      if (advance) begin
         wait_nx = legal ? 4'(WAIT_STATES) : '0;
      end else if (wait_cnt != '0) begin
         wait_nx = wait_cnt - 4'd1;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= STATE_IDLE;
         wait_cnt <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         size_q   <= SIZE_BYTE;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         if (advance) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= ahb_size_t'(HSIZE);
         end
      end
   end

   assign idx = IDX_W'((addr_q - BASE_ADDR) >> LOG2_LANES);

   ahb_byte_lane_dec #(
      .DATA_W (DATA_W)
   ) u_lane_dec (
      .size    (size_q),
      .addr_lo (addr_q[LANE_AW-1:0]),
      .strb    (strb)
   );

   assign wr_fire = (state == STATE_WRITE) && write_q && (wait_cnt == '0);

   // Memory has no reset; the HRESET gate drops a write whose completion edge coincides with reset.
   always_ff @(posedge HCLK) begin
      if (wr_fire && !HRESET) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (strb[i]) begin
               mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

   assign HREADYOUT = ready_int;
   assign HRESP     = resp_int;
   assign HRDATA    = ((state == STATE_READ) && !write_q) ? mem[idx] : '0;

endmodule

// File: tb/tb_ahb_sub_mem.sv
// Bench for ahb_sub_mem: three instances (WAIT_STATES 0/2/3) on a shared bus, vector tables
// driven through a pipelined AHB driver with an expected-response queue, plus hand sequences.
`timescale 1ns/1ps
module tb_ahb_sub_mem;
   import AHBCommon_pkg::*;

   localparam int NDUT = 3;
   localparam int unsigned WS_TAB [NDUT] = '{0, 2, 3};

   logic        clk = 1'b0;
   logic        hreset = 1'b1;
   logic        hsel_bus;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;

   logic        hreadyout [NDUT];
   logic [1:0]  hresp     [NDUT];
   logic [31:0] hrdata    [NDUT];

   int          dsel = 0;
   logic        ro;
   logic [1:0]  resp_sel;
   logic [31:0] rdata_sel;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ahb_sub_mem #(
         .ADDR_W      (32),
         .DATA_W      (32),
         .DEPTH       (256),
         .BASE_ADDR   (32'h0000_0000),
         .WAIT_STATES (WS_TAB[g])
      ) u_dut (
         .HCLK      (clk),
         .HRESET    (hreset),
         .HSEL      (hsel_bus && (dsel == g)),
         .HADDR     (haddr),
         .HTRANS    (htrans),
         .HWRITE    (hwrite),
         .HSIZE     (hsize),
         .HWDATA    (hwdata),
         .HREADY    (hreadyout[g]),
         .HREADYOUT (hreadyout[g]),
         .HRESP     (hresp[g]),
         .HRDATA    (hrdata[g])
      );
   end

   assign ro        = hreadyout[dsel];
   assign resp_sel  = hresp[dsel];
   assign rdata_sel = hrdata[dsel];

   typedef struct {
      logic        sel;
      ahb_trans_t  trans;
      logic        write;
      logic [31:0] addr;
      ahb_size_t   size;
      logic [31:0] wdata;
      ahb_resp_t   exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      ahb_resp_t   resp;
      logic [31:0] rdata;
      int          waits;
      int          id;
   } exp_t;

   vec_t vt [$];
   exp_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void add(input logic sel, input ahb_trans_t t, input logic w,
                               input logic [31:0] a, input ahb_size_t s, input logic [31:0] wd,
                               input ahb_resp_t er, input logic [31:0] ed);
      vt.push_back('{sel, t, w, a, s, wd, er, ed});
   endfunction

   task automatic drive_idle();
      hsel_bus = 1'b0;
      htrans   = TRANS_IDLE;
      hwrite   = 1'b0;
      haddr    = '0;
      hsize    = SIZE_WORD;
   endtask

   task automatic drive_addr(input logic sel, input ahb_trans_t t, input logic w,
                             input logic [31:0] a, input ahb_size_t s);
      hsel_bus = sel;
      htrans   = t;
      hwrite   = w;
      haddr    = a;
      hsize    = s;
   endtask

   // Drives vt[first..last] back to back; each cycle is observed 1ns after the rising edge.
   task automatic run_table(input int first, input int last);
      int          vi, waits, guard, cur_id;
      bit          pend, nxt;
      logic [31:0] nwd;
      logic        r;
      vec_t        v;
      exp_t        e;
      vi = first; waits = 0; guard = 0; pend = 0; nxt = 0; nwd = '0; cur_id = 0;
      while ((vi <= last || pend || nxt) && guard < 400) begin
         @(posedge clk); #1;
         guard++;
         if (nxt) begin
            pend = 1; nxt = 0; waits = 0;
            hwdata = nwd;
         end
         r = ro;
         if (pend && sb.size() > 0) begin
            cur_id = sb[0].id;
            if (!r) begin
               waits++;
               check($sformatf("v%0d wait-cycle HRESP", cur_id), 32'(resp_sel), 32'(sb[0].resp));
            end else begin
               e = sb.pop_front();
               check($sformatf("v%0d HRESP", e.id), 32'(resp_sel), 32'(e.resp));
               check($sformatf("v%0d HRDATA", e.id), rdata_sel, e.rdata);
               check($sformatf("v%0d wait count", e.id), 32'(waits), 32'(e.waits));
               pend = 0;
            end
         end else begin
            check("idle HREADYOUT", 32'(r), 32'd1);
            check("idle HRESP", 32'(resp_sel), 32'(RESP_OKAY));
            check("idle HRDATA", rdata_sel, 32'h0);
         end
         if (r) begin
            if (vi <= last) begin
               v = vt[vi];
               drive_addr(v.sel, v.trans, v.write, v.addr, v.size);
               if (v.sel && trans_active(v.trans)) begin
                  sb.push_back('{v.exp_resp, v.exp_rdata,
                                 (v.exp_resp == RESP_OKAY) ? int'(WS_TAB[dsel]) : 1, vi});
                  nxt = 1;
                  nwd = v.wdata;
               end
               vi++;
            end else begin
               drive_idle();
            end
         end
      end
      if (guard >= 400) begin
         n_checks++; n_fail++;
         $display("FAIL run_table timeout: got %0d cycles, expected under 400", guard);
      end
      sb.delete();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int s0a, s0b, s1a, s1b, s1c, s1d, s2a, s2b, s2c, s2d, s3a, s3b;
      drive_idle();
      hwdata = '0;

      // WAIT_STATES=0 instance
      s0a = vt.size();
      add(1, TRANS_NONSEQ, 1, 32'h000, SIZE_WORD,  32'h0BAD_F00D, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 1, 32'h010, SIZE_WORD,  32'hDEAD_BEEF, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h010, SIZE_WORD,  32'hFFFF_FFFF, RESP_OKAY,  32'hDEAD_BEEF);
      add(1, TRANS_NONSEQ, 1, 32'h010, SIZE_WORD,  32'h1122_3344, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 1, 32'h013, SIZE_BYTE,  32'hAA55_6677, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h010, SIZE_WORD,  32'h0,         RESP_OKAY,  32'hAA22_3344);
      add(1, TRANS_IDLE,   1, 32'h010, SIZE_WORD,  32'h0,         RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h400, SIZE_WORD,  32'h0,         RESP_ERROR, 32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h000, SIZE_WORD,  32'h0,         RESP_OKAY,  32'h0BAD_F00D);
      add(1, TRANS_NONSEQ, 0, 32'h011, SIZE_HALF,  32'h0,         RESP_ERROR, 32'h0);
      add(1, TRANS_NONSEQ, 1, 32'h011, SIZE_HALF,  32'hFFFF_FFFF, RESP_ERROR, 32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h010, SIZE_DWORD, 32'h0,         RESP_ERROR, 32'h0);
      add(1, TRANS_NONSEQ, 1, 32'h010, SIZE_DWORD, 32'h0000_0000, RESP_ERROR, 32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h012, SIZE_WORD,  32'h0,         RESP_ERROR, 32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h010, SIZE_WORD,  32'h0,         RESP_OKAY,  32'hAA22_3344);
      add(1, TRANS_NONSEQ, 1, 32'h020, SIZE_WORD,  32'h5566_7788, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 1, 32'h022, SIZE_HALF,  32'hCAFE_1234, RESP_OKAY,  32'h0);
      add(1, TRANS_SEQ,    0, 32'h020, SIZE_WORD,  32'h0,         RESP_OKAY,  32'hCAFE_7788);
      add(1, TRANS_BUSY,   0, 32'h024, SIZE_WORD,  32'h0,         RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 1, 32'h021, SIZE_BYTE,  32'h0000_9900, RESP_OKAY,  32'h0);
      add(0, TRANS_NONSEQ, 1, 32'h020, SIZE_WORD,  32'h0,         RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h020, SIZE_WORD,  32'h0,         RESP_OKAY,  32'hCAFE_9988);
      add(1, TRANS_NONSEQ, 1, 32'h3FC, SIZE_WORD,  32'h1234_5678, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h3FF, SIZE_BYTE,  32'h0,         RESP_OKAY,  32'h1234_5678);
      add(1, TRANS_NONSEQ, 0, 32'hFFFF_FFFC, SIZE_WORD, 32'h0,    RESP_ERROR, 32'h0);
      s0b = vt.size() - 1;

      // WAIT_STATES=2 instance
      s1a = vt.size();
      add(1, TRANS_NONSEQ, 1, 32'h040, SIZE_WORD,  32'h0102_0304, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h040, SIZE_WORD,  32'h0,         RESP_OKAY,  32'h0102_0304);
      add(1, TRANS_NONSEQ, 1, 32'h044, SIZE_WORD,  32'h7777_7777, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h400, SIZE_WORD,  32'h0,         RESP_ERROR, 32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h044, SIZE_WORD,  32'h0,         RESP_OKAY,  32'h7777_7777);
      s1b = vt.size() - 1;
      s1c = vt.size();
      add(1, TRANS_NONSEQ, 0, 32'h044, SIZE_WORD,  32'h0,         RESP_OKAY,  32'h7777_7777);
      s1d = vt.size() - 1;

      // WAIT_STATES=3 instance
      s2a = vt.size();
      add(1, TRANS_NONSEQ, 1, 32'h080, SIZE_WORD,  32'hA5A5_A5A5, RESP_OKAY,  32'h0);
      add(1, TRANS_NONSEQ, 0, 32'h080, SIZE_WORD,  32'h0,         RESP_OKAY,  32'hA5A5_A5A5);
      s2b = vt.size() - 1;
      s2c = vt.size();
      add(1, TRANS_NONSEQ, 0, 32'h080, SIZE_WORD,  32'h0,         RESP_OKAY,  32'hA5A5_A5A5);
      s2d = vt.size() - 1;

      // Back on the zero-wait instance: memory survives the reset pulse
      s3a = vt.size();
      add(1, TRANS_NONSEQ, 0, 32'h010, SIZE_WORD,  32'h0,         RESP_OKAY,  32'hAA22_3344);
      s3b = vt.size() - 1;

      #1;
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("dut%0d reset HREADYOUT", k), 32'(hreadyout[k]), 32'd1);
         check($sformatf("dut%0d reset HRESP", k), 32'(hresp[k]), 32'(RESP_OKAY));
         check($sformatf("dut%0d reset HRDATA", k), hrdata[k], 32'h0);
      end
      repeat (2) @(posedge clk);
      #1 hreset = 1'b0;

      dsel = 0;
      run_table(s0a, s0b);

      dsel = 1;
      run_table(s1a, s1b);
      // Address phase offered while HREADY is low must be ignored; HSEL then drops mid data phase.
      @(posedge clk); #1;
      drive_addr(1, TRANS_NONSEQ, 0, 32'h040, SIZE_WORD);
      @(posedge clk); #1;
      check("hs1 wait1 HREADYOUT", 32'(ro), 32'd0);
      drive_addr(1, TRANS_NONSEQ, 1, 32'h044, SIZE_WORD);
      hwdata = 32'h0;
      @(posedge clk); #1;
      check("hs1 wait2 HREADYOUT", 32'(ro), 32'd0);
      drive_idle();
      @(posedge clk); #1;
      check("hs1 done HREADYOUT", 32'(ro), 32'd1);
      check("hs1 done HRESP", 32'(resp_sel), 32'(RESP_OKAY));
      check("hs1 done HRDATA", rdata_sel, 32'h0102_0304);
      run_table(s1c, s1d);

      dsel = 2;
      run_table(s2a, s2b);
      // Reset lands in the middle of a stalled write; the write must be dropped.
      @(posedge clk); #1;
      drive_addr(1, TRANS_NONSEQ, 1, 32'h080, SIZE_WORD);
      @(posedge clk); #1;
      hwdata = 32'h5A5A_5A5A;
      drive_idle();
      check("hs2 wait1 HREADYOUT", 32'(ro), 32'd0);
      @(posedge clk); #1;
      check("hs2 wait2 HREADYOUT", 32'(ro), 32'd0);
      #2 hreset = 1'b1;
      #1;
      check("hs2 async reset HREADYOUT", 32'(ro), 32'd1);
      check("hs2 async reset HRESP", 32'(resp_sel), 32'(RESP_OKAY));
      check("hs2 async reset HRDATA", rdata_sel, 32'h0);
      repeat (2) @(posedge clk);
      #1 hreset = 1'b0;
      run_table(s2c, s2d);

      dsel = 0;
      run_table(s3a, s3b);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
